// File: rtl/uart_mem_dump_pkg.sv
// Shared constants and FSM state type for the serial memory dump engine.
// The optional trailing checksum frame is enabled by defining DUMP_CHECKSUM_EN.
package uart_mem_dump_pkg;

   localparam int UART_FRAME_BITS = 10;
   localparam int BYTES_PER_WORD  = 4;
   localparam int ADR_DMEM_BIT    = 14;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LATCH,
      S_FRAME,
`ifdef DUMP_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_e;

endpackage

// File: rtl/uart_mem_dump_tx_byte.sv
// 8N1 byte transmitter: owns the baud counter and bit index, and accepts a new
// byte in the same cycle as the stop-bit end so that frames run back to back.
module uart_tx_byte
   import uart_mem_dump_pkg::*;
#(
   parameter int BAUD_DIV = 87
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       load_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       last_o
);

   logic        active_q, active_d;
   logic [15:0] baud_q, baud_d;
   logic [3:0]  bit_q, bit_d;
   logic [8:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        bit_end;

   // NOTE: every combinational output gets a default first, so no path leaves a latch.
   always_comb begin
      active_d = active_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      bit_end  = active_q && (baud_q == 16'(BAUD_DIV - 1));
      last_o   = bit_end && (bit_q == 4'(UART_FRAME_BITS - 1));

      if (active_q) baud_d = bit_end ? '0 : baud_q + 16'd1;
      if (bit_end) begin
         if (last_o) begin
            active_d = 1'b0;
            tx_d     = 1'b1;
         end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
         end
      end
      // Shift register holds {stop, data}; the start bit is driven directly.
      if (load_i) begin
         active_d = 1'b1;
         baud_d   = '0;
         bit_d    = '0;
         tx_d     = 1'b0;
         shift_d  = {1'b1, data_i};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, avoiding update-order races.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '1;
         tx_q     <= 1'b1;
      end else begin
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = active_q;

endmodule

// File: rtl/uart_mem_dump.sv
// Reads a contiguous word range from the upload address space and streams it
// out little-endian as 8N1 frames. DUMP_CHECKSUM_EN appends a mod-256 sum frame.
module uart_mem_dump
   import uart_mem_dump_pkg::*;
#(
   parameter int BAUD_DIV = 87,
   parameter int ADR_W    = 15
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [ADR_W-1:0] start_adr_i,
   input  logic [ADR_W-1:0] word_cnt_i,
   input  logic             abort_i,
   output logic             mem_ren_o,
   output logic [ADR_W-1:0] mem_adr_o,
   input  logic [31:0]      mem_dat_i,
   output logic             tx_o,
   output logic             busy_o,
   output logic             done_o
);

   state_e           state_q, state_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [ADR_W-1:0] cnt_q, cnt_d;
   logic [31:0]      word_q, word_d;
   logic [1:0]       byte_q, byte_d;
   logic             abort_q, abort_d;
   logic             tx_load, tx_busy, tx_last;
   logic [7:0]       tx_data;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;
`endif

   uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .load_i (tx_load),
      .data_i (tx_data),
      .tx_o   (tx_o),
      .busy_o (tx_busy),
      .last_o (tx_last)
   );

   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      byte_d    = byte_q;
      abort_d   = abort_q;
      mem_ren_o = 1'b0;
      done_o    = 1'b0;
      tx_load   = 1'b0;
      tx_data   = 8'h00;
`ifdef DUMP_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      if (state_q != S_IDLE) abort_d = abort_q | abort_i;

      unique case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            if (start_i) begin
               adr_d   = start_adr_i;
               cnt_d   = word_cnt_i;
`ifdef DUMP_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
               state_d = (word_cnt_i == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            mem_ren_o = 1'b1;
            state_d   = S_LATCH;
         end
         S_LATCH: begin
            word_d  = mem_dat_i;
            byte_d  = 2'd0;
            tx_load = 1'b1;
            tx_data = mem_dat_i[7:0];
`ifdef DUMP_CHECKSUM_EN
            csum_d  = csum_q + mem_dat_i[7:0];
`endif
            state_d = S_FRAME;
         end
         S_FRAME: begin
            if (tx_last) begin
               if (abort_q || abort_i) begin
                  state_d = S_IDLE;
               end else if (byte_q != 2'(BYTES_PER_WORD - 1)) begin
                  // word_q is shifted down one byte per frame, so byte 1 is always next.
                  byte_d  = byte_q + 2'd1;
                  word_d  = {8'h00, word_q[31:8]};
                  tx_load = 1'b1;
                  tx_data = word_q[15:8];
`ifdef DUMP_CHECKSUM_EN
                  csum_d  = csum_q + word_q[15:8];
`endif
               end else begin
                  cnt_d = cnt_q - ADR_W'(1);
                  adr_d = adr_q + ADR_W'(1);
                  if (cnt_q != ADR_W'(1)) begin
                     state_d = S_READ;
                  end else begin
`ifdef DUMP_CHECKSUM_EN
                     tx_load = 1'b1;
                     tx_data = csum_q;
                     state_d = S_CSUM;
`else
                     state_d = S_DONE;
`endif
                  end
               end
            end
         end
`ifdef DUMP_CHECKSUM_EN
         S_CSUM: begin
            if (tx_last) state_d = (abort_q || abort_i) ? S_IDLE : S_DONE;
         end
`endif
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         byte_q  <= '0;
         abort_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         byte_q  <= byte_d;
         abort_q <= abort_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign mem_adr_o = adr_q;
   assign busy_o    = (state_q != S_IDLE) || tx_busy;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump at BAUD_DIV=4 with an independent UART receiver.
// Expectations follow DUMP_CHECKSUM_EN when the bench is built with it defined.
module tb_uart_mem_dump;

   localparam int B        = 4;
   localparam int ADR_W    = 15;
   localparam int WORD_CYC = 40 * B + 2;
`ifdef DUMP_CHECKSUM_EN
   localparam int CSUM_CYC = 10 * B;
`else
   localparam int CSUM_CYC = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [ADR_W-1:0] start_adr;
   logic [ADR_W-1:0] word_cnt;
   logic             abort;
   logic             mem_ren;
   logic [ADR_W-1:0] mem_adr;
   logic [31:0]      mem_dat;
   logic             tx;
   logic             busy;
   logic             done;

   logic [31:0]      mem [0:32767];
   logic [ADR_W-1:0] reads [$];
   logic [7:0]       frames [$];
   int               cyc = 0;
   int               done_cnt = 0;
   int               txlow_cnt = 0;
   int               stop_err = 0;
   int               n_vec = 0;
   int               n_err = 0;
   int               s_cyc;

   always #5 clk = ~clk;

   uart_mem_dump #(.BAUD_DIV(B), .ADR_W(ADR_W)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .start_adr_i(start_adr),
      .word_cnt_i (word_cnt),
      .abort_i    (abort),
      .mem_ren_o  (mem_ren),
      .mem_adr_o  (mem_adr),
      .mem_dat_i  (mem_dat),
      .tx_o       (tx),
      .busy_o     (busy),
      .done_o     (done)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_ren) begin
         mem_dat <= mem[mem_adr];
         reads.push_back(mem_adr);
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (!tx) txlow_cnt <= txlow_cnt + 1;
   end

   // Receiver: detect the start bit, then sample each bit near its middle.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            logic [7:0] b;
            repeat (B / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (B) @(negedge clk);
               b[i] = tx;
            end
            repeat (B) @(negedge clk);
            if (tx !== 1'b1) stop_err++;
            frames.push_back(b);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_dump(input logic [ADR_W-1:0] adr, input logic [ADR_W-1:0] cnt);
      @(negedge clk);
      start_adr = adr;
      word_cnt  = cnt;
      start     = 1'b1;
      s_cyc     = cyc;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int lat = -1;
      for (int i = 0; i < 2000; i++) begin
         if (done === 1'b1) begin
            lat = cyc - s_cyc;
            break;
         end
         @(negedge clk);
      end
      check(tag, 32'(lat), 32'(exp_lat));
   endtask

   task automatic check_frames(input string tag, input int fb, input int n, input logic [31:0] w [0:2]);
      logic [7:0] exp [$];
      logic [7:0] sum = 8'h00;
      for (int k = 0; k < n; k++)
         for (int j = 0; j < 4; j++) begin
            exp.push_back(w[k][8*j +: 8]);
            sum = sum + w[k][8*j +: 8];
         end
`ifdef DUMP_CHECKSUM_EN
      if (n > 0) exp.push_back(sum);
`endif
      check($sformatf("%s_nframes", tag), 32'(frames.size() - fb), 32'(exp.size()));
      for (int i = 0; i < exp.size() && fb + i < frames.size(); i++)
         check($sformatf("%s_frame%0d", tag, i), 32'(frames[fb + i]), 32'(exp[i]));
   endtask

   initial begin
      int rb, fb, db, tb_low, lat;
      logic [31:0] w [0:2];

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_adr = '0; word_cnt = '0;
      mem[15'h0000] = 32'h12345678;
      mem[15'h7FFF] = 32'hAABBCCDD;
      mem[15'h4000] = 32'h01020304;
      mem[15'h4001] = 32'h05060708;
      mem[15'h4002] = 32'h090A0B0C;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ren", 32'(mem_ren), 32'd0);
      check("rst_adr", 32'(mem_adr), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single word: read/latch/start-bit timing, latency, byte order.
      rb = reads.size(); fb = frames.size();
      start_dump(15'h0000, 15'd1);
      check("w1_read_ren", 32'(mem_ren), 32'd1);
      check("w1_read_adr", 32'(mem_adr), 32'h0000);
      check("w1_busy", 32'(busy), 32'd1);
      check("w1_read_tx", 32'(tx), 32'd1);
      @(negedge clk);
      check("w1_latch_ren", 32'(mem_ren), 32'd0);
      check("w1_latch_tx", 32'(tx), 32'd1);
      @(negedge clk);
      check("w1_startbit", 32'(tx), 32'd0);
      wait_done("w1_done_lat", 1 + WORD_CYC + CSUM_CYC);
      @(negedge clk);
      check("w1_busy_fall", 32'(busy), 32'd0);
      check("w1_nreads", 32'(reads.size() - rb), 32'd1);
      if (reads.size() > rb) check("w1_read0", 32'(reads[rb]), 32'h0000);
      w = '{32'h12345678, 32'h0, 32'h0};
      check_frames("w1", fb, 1, w);

      // Zero count: immediate done, nothing read, line stays high.
      repeat (4) @(negedge clk);
      rb = reads.size(); fb = frames.size(); tb_low = txlow_cnt;
      start_dump(15'h1234, 15'd0);
      wait_done("z_done_lat", 1);
      @(negedge clk);
      check("z_busy_fall", 32'(busy), 32'd0);
      repeat (20 * B) @(negedge clk);
      check("z_nreads", 32'(reads.size() - rb), 32'd0);
      check("z_nframes", 32'(frames.size() - fb), 32'd0);
      check("z_txlow", 32'(txlow_cnt - tb_low), 32'd0);

      // Address wrap 0x7FFF -> 0x0000.
      rb = reads.size(); fb = frames.size();
      start_dump(15'h7FFF, 15'd2);
      wait_done("wrap_done_lat", 1 + 2 * WORD_CYC + CSUM_CYC);
      check("wrap_nreads", 32'(reads.size() - rb), 32'd2);
      if (reads.size() > rb + 1) begin
         check("wrap_read0", 32'(reads[rb]), 32'h7FFF);
         check("wrap_read1", 32'(reads[rb + 1]), 32'h0000);
      end
      w = '{32'hAABBCCDD, 32'h12345678, 32'h0};
      check_frames("wrap", fb, 2, w);

      // Abort mid second frame: that frame completes, no done, back to idle.
      repeat (4) @(negedge clk);
      fb = frames.size(); db = done_cnt;
      start_dump(15'h4000, 15'd3);
      for (int i = 0; i < 200 && (cyc - s_cyc) < 60; i++) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      lat = -1;
      for (int i = 0; i < 500; i++) begin
         if (busy === 1'b0) begin
            lat = cyc - s_cyc;
            break;
         end
         @(negedge clk);
      end
      check("abort_idle_lat", 32'(lat), 32'd83);
      repeat (30 * B) @(negedge clk);
      check("abort_done", 32'(done_cnt - db), 32'd0);
      check("abort_nframes", 32'(frames.size() - fb), 32'd2);
      if (frames.size() > fb + 1) begin
         check("abort_frame0", 32'(frames[fb]), 32'h04);
         check("abort_frame1", 32'(frames[fb + 1]), 32'h03);
      end

      // Data-memory word after abort (also the checksum vector when enabled).
      fb = frames.size();
      start_dump(15'h4000, 15'd1);
      wait_done("dmem_done_lat", 1 + WORD_CYC + CSUM_CYC);
      w = '{32'h01020304, 32'h0, 32'h0};
      check_frames("dmem", fb, 1, w);

      // Restart while busy is ignored; reset mid-bit acts asynchronously.
      repeat (4) @(negedge clk);
      rb = reads.size();
      start_dump(15'h0000, 15'd2);
      @(negedge clk);
      start_adr = 15'h0100; word_cnt = 15'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 100 && tx !== 1'b0; i++) @(negedge clk);
      check("rs_tx_low", 32'(tx), 32'd0);
      check("rs_adr_kept", 32'(mem_adr), 32'h0000);
      check("rs_nreads", 32'(reads.size() - rb), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rs_async_tx", 32'(tx), 32'd1);
      check("rs_async_busy", 32'(busy), 32'd0);
      check("rs_async_ren", 32'(mem_ren), 32'd0);
      check("rs_async_adr", 32'(mem_adr), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15 * B) @(negedge clk);
      check("rs_idle_busy", 32'(busy), 32'd0);
      check("stop_bits", 32'(stop_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_mem_dump.md
# uart_mem_dump

Serial memory read-back engine: the transmit-side counterpart of the UART program loader. On command it reads a contiguous range of 32-bit words from the unified 15-bit upload address space (bit 14 = 0 instruction memory, bit 14 = 1 data memory) and streams the words out as 8N1 UART frames. It sits beside the loader at CPU top level, shares its address map, and drives `tx` when the loader is idle.

## Interface
Parameters:
- `BAUD_DIV`, 87: clock cycles per UART bit; legal range 2..65535.
- `ADR_W`, 15: word address width, matching the upload address map.

Ports:
- `clk_i`  in  1  — single clock.
- `rst_n_i`  in  1  — reset, asynchronous, active-low.
- `start_i`  in  1  — one-cycle request; sampled only in IDLE.
- `start_adr_i`  in  ADR_W  — first word address, captured with `start_i`.
- `word_cnt_i`  in  ADR_W  — number of words to send, captured with `start_i`.
- `abort_i`  in  1  — stop the dump at the next frame boundary.
- `mem_ren_o`  out  1  — one-cycle read strobe.
- `mem_adr_o`  out  ADR_W  — read address.
- `mem_dat_i`  in  32  — read data, valid exactly 1 cycle after `mem_ren_o`.
- `tx_o`  out  1  — serial output, idle high.
- `busy_o`  out  1  — high from the cycle after start acceptance until return to IDLE.
- `done_o`  out  1  — one-cycle pulse on normal completion.

## Operation
- FSM states: IDLE, READ, LATCH, FRAME, DONE (plus CSUM when `DUMP_CHECKSUM_EN` is defined).
- IDLE: `start_i`=1 captures address and count. If count = 0, go to DONE. Otherwise go to READ.
- READ: `mem_ren_o`=1 and `mem_adr_o` = current address; go to LATCH.
- LATCH: capture `mem_dat_i` into a 32-bit shift word, set the byte index to 0, and go to FRAME.
- FRAME: send byte[index], little-endian (bits 7:0 first). Each frame is a start bit (0), 8 data bits LSB-first, and a stop bit (1). Every bit lasts BAUD_DIV cycles.
- At the end of each stop bit:
  - if an abort is pending, go to IDLE with no `done_o`;
  - else if index < 3, increment index and send the next frame;
  - else decrement the remaining count, increment the address modulo 2^ADR_W, and go to READ if count > 0, otherwise DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `abort_i` sets a sticky flag while busy; the flag clears in IDLE. A frame that has started is always completed, so no partial frame is ever sent.
- `start_i` while busy is ignored.
- Address wraps 0x7FFF → 0x0000 without error.

## Timing
- Reset values: `tx_o`=1, `busy_o`=0, `done_o`=0, `mem_ren_o`=0, `mem_adr_o`=0. State = IDLE and all counters = 0.
- Reset asserted mid-frame forces `tx_o` high immediately and asynchronously.
- Start accepted at edge E:
  - READ during cycle E+1;
  - LATCH during E+2;
  - start bit (`tx_o`=0) begins at E+3.
- Per word: 40·BAUD_DIV + 2 cycles.
- N words with N ≥ 1: `done_o` is high in cycle E+1 + N·(40·BAUD_DIV+2); `busy_o` falls on the next cycle.
- Count = 0: `done_o` is high in E+1, with no read and no frames.
- The bit counter runs 0..BAUD_DIV−1, and the bit value changes only when the counter wraps.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - a running 8-bit sum (mod 256) accumulates every data byte sent;
  - after the last word, state CSUM sends one extra frame carrying that sum, then goes to DONE;
  - N-word latency grows by 10·BAUD_DIV;
  - count = 0 sends nothing;
  - abort suppresses the checksum.
- Undefined: no accumulator and no CSUM state; exactly 4·N frames are sent.

## Structure
- Shared package holds:
  - the FSM state enum;
  - `UART_FRAME_BITS` = 10;
  - `BYTES_PER_WORD` = 4;
  - address-map constants `ADR_DMEM_BIT` = 14.
- One sub-module, `uart_tx_byte`:
  - inputs `load`/`data[7:0]`; outputs `tx`/`busy`/`last` (a pulse at the end of the stop bit);
  - owns the baud counter and bit index;
  - the parent owns the word, byte index and checksum.

## Test plan
- BAUD_DIV=4, start_adr=0x0000, count=1, mem[0]=0x12345678 → one read at address 0x0000; frames 0x78, 0x56, 0x34, 0x12; `done_o` at E+163.
- count=0 → `done_o` at E+1; `mem_ren_o` never asserts; `tx_o` stays high.
- start_adr=0x7FFF, count=2 → reads at 0x7FFF then 0x0000; 8 frames.
- `abort_i` pulsed mid-way through the second frame of a 3-word dump → the second frame completes; idle within 1 cycle of its stop bit; no `done_o`; total frames = 2.
- `start_i` re-pulsed while busy, then reset asserted mid-bit → the second start is ignored; on reset `tx_o`=1, `busy_o`=0 asynchronously.
- With `DUMP_CHECKSUM_EN`, mem[0x4000]=0x01020304, count=1 → frames 04 03 02 01 then 0x0A.
